eth_mac_rx_frame_queue: RTL and testbench

- Parametrised store-and-forward receive frame queue for the MAC's direct RX data path. Sits in the clk_app_i domain between the MAC RX stream (rx_valid/rx_data/rx_start/rx_end/rx_bytesel/rx_status) and a user consumer with valid/ready backpressure.
- Buffers up to FRAMES complete frames in a shared word RAM. Commits a frame only on its end beat. Drops errored, oversize or overflowing frames whole, and counts the drops.

---
 rtl/eth_mac_rx_frame_queue.sv | 155 +++++++++++++++
 tb/tb_eth_mac_rx_frame_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_mac_rx_frame_queue.sv
// eth_mac_rx_frame_queue: store-and-forward RX frame queue; commits whole frames, drops bad ones, FWFT output.
module eth_mac_rx_frame_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 512,
  parameter int FRAMES = 16,
  parameter int MAX_LEN = 1518,
  parameter int DROP_ERR = 1,
  parameter logic [7:0] ERR_MASK = 8'hE0,
  localparam int BW = $clog2(DATA_W / 8),
  localparam int CW = $clog2(FRAMES) + 1
) (
  input  logic              clk_app_i,
  input  logic              rst_clk_app_n,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_start_i,
  input  logic              rx_end_i,
  input  logic [BW-1:0]     rx_bytesel_i,
  input  logic [7:0]        rx_status_i,
  output logic              frm_valid_o,
  input  logic              frm_ready_i,
  output logic [DATA_W-1:0] frm_data_o,
  output logic              frm_start_o,
  output logic              frm_end_o,
  output logic [BW-1:0]     frm_bytesel_o,
  output logic [7:0]        frm_status_o,
  output logic [13:0]       frm_len_o,
  output logic [CW-1:0]     frm_count_o,
  output logic [15:0]       drop_cnt_o,
  input  logic              drop_clr_i
);
  localparam int BYTES = DATA_W / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = CW - 1;
  localparam int RW = DATA_W + 2 + BW;

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;
  state_t st, st_n;

  logic [AW:0] wr_ptr, wr_ptr_n, wr_commit, wr_commit_n, rd_ptr, base_ptr;
  logic [15:0] wcnt, wcnt_n, base_cnt, last_bytes, new_len, drop_n;
  logic [16:0] drop_sum;
  logic [1:0] drop_inc;
  logic [CW-1:0] count_n;
  logic sof, fifo_full, ram_full, err, bad, we, push, pop, drop_a, drop_b;
  logic r_valid, pop_out, load_out, rd_en, avail;
  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] ram_q;
  logic [21:0] fifo [FRAMES];
  logic [FW-1:0] fwp, frp;

  assign sof = rx_valid_i && rx_start_i;
  assign fifo_full = frm_count_o == CW'(FRAMES);
  assign base_ptr = sof ? wr_commit : wr_ptr;
  assign base_cnt = sof ? '0 : wcnt;
  assign last_bytes = (rx_end_i && rx_bytesel_i != '0) ? 16'(rx_bytesel_i) : 16'(BYTES);
  assign new_len = (base_cnt << BW) + last_bytes;
  // the full test is against rd_ptr, so committed or unread data is never overwritten
  assign ram_full = (base_ptr - rd_ptr) == PW'(DEPTH);
  assign err = (DROP_ERR != 0) && |(rx_status_i & ERR_MASK);
  assign bad = ram_full || new_len > 16'(MAX_LEN);

  always_comb begin
    st_n = st;
    wr_ptr_n = wr_ptr;
    wr_commit_n = wr_commit;
    wcnt_n = wcnt;
    we = 1'b0;
    push = 1'b0;
    drop_a = sof && st == RECV;
    drop_b = 1'b0;
    if (rx_valid_i && (sof || st != IDLE)) begin
      if ((!sof && st == DISCARD) || (sof && fifo_full) || bad) begin
        wr_ptr_n = wr_commit;
        drop_b = rx_end_i;
        st_n = rx_end_i ? IDLE : DISCARD;
      end else if (rx_end_i) begin
        we = 1'b1;
        st_n = IDLE;
        push = !err;
        drop_b = err;
        wr_ptr_n = err ? wr_commit : base_ptr + 1'b1;
        wr_commit_n = err ? wr_commit : base_ptr + 1'b1;
      end else begin
        we = 1'b1;
        st_n = RECV;
        wr_ptr_n = base_ptr + 1'b1;
        wcnt_n = base_cnt + 16'd1;
      end
    end
  end

  assign drop_inc = 2'(drop_a) + 2'(drop_b);
  assign drop_sum = 17'(drop_cnt_o) + 17'(drop_inc);
  assign drop_n = drop_clr_i ? 16'd0 : drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  assign avail = rd_ptr != wr_commit;
  assign pop_out = frm_valid_o && frm_ready_i;
  assign load_out = r_valid && (!frm_valid_o || pop_out);
  assign rd_en = avail && (!r_valid || load_out);
  assign pop = pop_out && frm_end_o;
  assign count_n = frm_count_o + CW'(push) - CW'(pop);
  assign {frm_status_o, frm_len_o} = fifo[frp];

  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      st <= IDLE;
      wr_ptr <= '0;
      wr_commit <= '0;
      wcnt <= '0;
      drop_cnt_o <= '0;
    end else begin
      st <= st_n;
      wr_ptr <= wr_ptr_n;
      wr_commit <= wr_commit_n;
      wcnt <= wcnt_n;
      drop_cnt_o <= drop_n;
    end
  end

  always_ff @(posedge clk_app_i) begin
    if (we) mem[base_ptr[AW-1:0]] <= {rx_start_i, rx_end_i, rx_bytesel_i, rx_data_i};
    if (rd_en) ram_q <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      for (int i = 0; i < FRAMES; i++) fifo[i] <= '0;
      fwp <= '0;
      frp <= '0;
      frm_count_o <= '0;
    end else begin
      if (push) fifo[fwp] <= {rx_status_i, new_len[13:0]};
      if (push) fwp <= fwp + 1'b1;
      if (pop) frp <= frp + 1'b1;
      frm_count_o <= count_n;
    end
  end

  // RAM read stage feeding an output register gives first-word-fall-through at full rate
  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      rd_ptr <= '0;
      r_valid <= 1'b0;
      frm_valid_o <= 1'b0;
      {frm_start_o, frm_end_o, frm_bytesel_o, frm_data_o} <= '0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      r_valid <= rd_en ? 1'b1 : load_out ? 1'b0 : r_valid;
      frm_valid_o <= load_out ? 1'b1 : pop_out ? 1'b0 : frm_valid_o;
      if (load_out) {frm_start_o, frm_end_o, frm_bytesel_o, frm_data_o} <= ram_q;
    end
  end
endmodule

// File: tb/tb_eth_mac_rx_frame_queue.sv
// tb_eth_mac_rx_frame_queue: scoreboard bench; one instance drops errored frames, a second delivers them.
module tb_eth_mac_rx_frame_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_valid = 1'b0, rx_start = 1'b0, rx_end = 1'b0, frm_ready = 1'b0, drop_clr = 1'b0, en0 = 1'b0;
  logic [31:0] rx_data = '0;
  logic [1:0] rx_bytesel = '0;
  logic [7:0] rx_status = '0;
  logic frm_valid, frm_start, frm_end;
  logic [31:0] frm_data;
  logic [1:0] frm_bytesel;
  logic [7:0] frm_status;
  logic [13:0] frm_len;
  logic [2:0] frm_count;
  logic [15:0] drop_cnt;
  logic z_valid, z_start, z_end;
  logic [31:0] z_data;
  logic [1:0] z_bytesel;
  logic [7:0] z_status;
  logic [13:0] z_len;
  logic [2:0] z_count;
  logic [15:0] z_drop;

  typedef struct {
    logic s;
    logic e;
    logic [1:0] bs;
    logic [31:0] d;
    logic [7:0] st;
    logic [13:0] len;
  } exp_t;
  exp_t sb[$];
  exp_t ex;
  int nc = 0, nf = 0, n_acc = 0;

  always #5 clk = ~clk;

  eth_mac_rx_frame_queue #(.DATA_W(32), .DEPTH(64), .FRAMES(4), .MAX_LEN(1518), .DROP_ERR(1), .ERR_MASK(8'hE0)) dut (
    .clk_app_i(clk), .rst_clk_app_n(rst_n), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .rx_start_i(rx_start), .rx_end_i(rx_end), .rx_bytesel_i(rx_bytesel), .rx_status_i(rx_status),
    .frm_valid_o(frm_valid), .frm_ready_i(frm_ready), .frm_data_o(frm_data), .frm_start_o(frm_start),
    .frm_end_o(frm_end), .frm_bytesel_o(frm_bytesel), .frm_status_o(frm_status), .frm_len_o(frm_len),
    .frm_count_o(frm_count), .drop_cnt_o(drop_cnt), .drop_clr_i(drop_clr));

  eth_mac_rx_frame_queue #(.DATA_W(32), .DEPTH(64), .FRAMES(4), .MAX_LEN(1518), .DROP_ERR(0), .ERR_MASK(8'hE0)) dut0 (
    .clk_app_i(clk), .rst_clk_app_n(rst_n), .rx_valid_i(rx_valid && en0), .rx_data_i(rx_data),
    .rx_start_i(rx_start), .rx_end_i(rx_end), .rx_bytesel_i(rx_bytesel), .rx_status_i(rx_status),
    .frm_valid_o(z_valid), .frm_ready_i(frm_ready), .frm_data_o(z_data), .frm_start_o(z_start),
    .frm_end_o(z_end), .frm_bytesel_o(z_bytesel), .frm_status_o(z_status), .frm_len_o(z_len),
    .frm_count_o(z_count), .drop_cnt_o(z_drop), .drop_clr_i(drop_clr));

  always @(negedge clk) begin
    if (rst_n && frm_valid && frm_ready) begin
      nc++;
      n_acc++;
      if (sb.size() == 0) begin
        nf++;
        $display("FAIL sb_extra: got word d=%h s=%b e=%b, required no word", frm_data, frm_start, frm_end);
      end else begin
        ex = sb.pop_front();
        if (frm_data !== ex.d || frm_start !== ex.s || frm_end !== ex.e || frm_status !== ex.st ||
            frm_len !== ex.len || (ex.e && frm_bytesel !== ex.bs)) begin
          nf++;
          $display("FAIL sb_word: got d=%h s=%b e=%b bs=%0d st=%h len=%0d, required d=%h s=%b e=%b bs=%0d st=%h len=%0d",
                   frm_data, frm_start, frm_end, frm_bytesel, frm_status, frm_len, ex.d, ex.s, ex.e, ex.bs, ex.st, ex.len);
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic s, input logic e, input logic [1:0] bs, input logic [7:0] st);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = d; rx_start = s; rx_end = e; rx_bytesel = bs; rx_status = st;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx_valid = 1'b0; rx_start = 1'b0; rx_end = 1'b0;
    end
  endtask

  task automatic send_frame(input int n, input logic [1:0] bs, input logic [7:0] st, input logic [7:0] tag, input bit want);
    int len = (n - 1) * 4 + (bs == 2'd0 ? 4 : int'(bs));
    for (int i = 0; i < n; i++) begin
      if (want) sb.push_back('{i == 0, i == n - 1, bs, {tag, 24'(i)}, st, 14'(len)});
      send_word({tag, 24'(i)}, i == 0, i == n - 1, bs, st);
    end
  endtask

  task automatic clear_drop();
    @(posedge clk); #1; drop_clr = 1'b1;
    @(posedge clk); #1; drop_clr = 1'b0;
  endtask

  task automatic wait_empty(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    nc++; if (frm_valid !== 1'b0) begin nf++; $display("FAIL rst_valid: got %b, required 0", frm_valid); end
    nc++; if ({frm_start, frm_end, frm_bytesel} !== 4'd0) begin nf++; $display("FAIL rst_flags: got %b, required 0", {frm_start, frm_end, frm_bytesel}); end
    nc++; if (frm_data !== 32'd0) begin nf++; $display("FAIL rst_data: got %h, required 0", frm_data); end
    nc++; if ({frm_status, frm_len} !== 22'd0) begin nf++; $display("FAIL rst_stlen: got %h, required 0", {frm_status, frm_len}); end
    nc++; if (frm_count !== 3'd0 || drop_cnt !== 16'd0) begin nf++; $display("FAIL rst_cnt: got count=%0d drop=%0d, required 0/0", frm_count, drop_cnt); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single();
    bit ok;
    frm_ready = 1'b1;
    send_frame(16, 2'd0, 8'h00, 8'h01, 1'b1);
    idle(1);
    nc++; if (frm_count !== 3'd1) begin nf++; $display("FAIL single_count1: got %0d, required 1", frm_count); end
    wait_empty(40, ok);
    nc++; if (!ok) begin nf++; $display("FAIL single_drain: got %0d words pending, required 0", sb.size()); end
    @(posedge clk); #1;
    nc++; if (frm_count !== 3'd0) begin nf++; $display("FAIL single_count0: got %0d, required 0", frm_count); end
  endtask

  task automatic test_bytesel();
    bit ok;
    frm_ready = 1'b1;
    send_frame(16, 2'd1, 8'h00, 8'h02, 1'b1);
    send_frame(1, 2'd3, 8'h00, 8'h03, 1'b1);
    idle(1);
    wait_empty(40, ok);
    nc++; if (!ok) begin nf++; $display("FAIL bytesel_drain: got %0d words pending, required 0", sb.size()); end
  endtask

  task automatic test_err();
    clear_drop();
    frm_ready = 1'b0;
    en0 = 1'b1;
    send_frame(4, 2'd0, 8'h20, 8'h04, 1'b0);
    idle(4);
    en0 = 1'b0;
    nc++; if (drop_cnt !== 16'd1) begin nf++; $display("FAIL err_drop: got %0d, required 1", drop_cnt); end
    nc++; if (frm_valid !== 1'b0 || frm_count !== 3'd0) begin nf++; $display("FAIL err_noout: got valid=%b count=%0d, required 0/0", frm_valid, frm_count); end
    nc++; if (z_valid !== 1'b1 || z_start !== 1'b1) begin nf++; $display("FAIL err_keep_valid: got valid=%b start=%b, required 1/1", z_valid, z_start); end
    nc++; if (z_status !== 8'h20 || z_len !== 14'd16) begin nf++; $display("FAIL err_keep_st: got st=%h len=%0d, required 20/16", z_status, z_len); end
    nc++; if (z_drop !== 16'd0) begin nf++; $display("FAIL err_keep_drop: got %0d, required 0", z_drop); end
    clear_drop();
    nc++; if (drop_cnt !== 16'd0) begin nf++; $display("FAIL drop_clr: got %0d, required 0", drop_cnt); end
    frm_ready = 1'b1;
    idle(8);
    nc++; if (z_count !== 3'd0 || z_valid !== 1'b0) begin nf++; $display("FAIL err_keep_drain: got count=%0d valid=%b, required 0/0", z_count, z_valid); end
  endtask

  task automatic test_overflow();
    bit ok;
    int a0;
    clear_drop();
    frm_ready = 1'b0;
    a0 = n_acc;
    send_frame(25, 2'd0, 8'h00, 8'h10, 1'b1);
    send_frame(25, 2'd0, 8'h00, 8'h11, 1'b1);
    send_frame(25, 2'd0, 8'h00, 8'h12, 1'b0);
    idle(3);
    nc++; if (drop_cnt !== 16'd1) begin nf++; $display("FAIL ovf_drop: got %0d, required 1", drop_cnt); end
    nc++; if (frm_count !== 3'd2) begin nf++; $display("FAIL ovf_count: got %0d, required 2", frm_count); end
    frm_ready = 1'b1;
    wait_empty(80, ok);
    idle(3);
    nc++; if (!ok) begin nf++; $display("FAIL ovf_drain: got %0d words pending, required 0", sb.size()); end
    nc++; if (n_acc - a0 !== 50) begin nf++; $display("FAIL ovf_words: got %0d, required 50", n_acc - a0); end
    nc++; if (frm_valid !== 1'b0) begin nf++; $display("FAIL ovf_idle: got valid=%b, required 0", frm_valid); end
  endtask

  task automatic test_abort();
    bit ok;
    int a0;
    clear_drop();
    frm_ready = 1'b1;
    a0 = n_acc;
    for (int i = 0; i < 10; i++) send_word({8'h20, 24'(i)}, i == 0, 1'b0, 2'd0, 8'h00);
    send_frame(4, 2'd2, 8'h01, 8'h21, 1'b1);
    idle(1);
    wait_empty(30, ok);
    idle(2);
    nc++; if (!ok) begin nf++; $display("FAIL abort_drain: got %0d words pending, required 0", sb.size()); end
    nc++; if (drop_cnt !== 16'd1) begin nf++; $display("FAIL abort_drop: got %0d, required 1", drop_cnt); end
    nc++; if (n_acc - a0 !== 4) begin nf++; $display("FAIL abort_words: got %0d, required 4", n_acc - a0); end
  endtask

  task automatic test_frames_full();
    bit ok;
    clear_drop();
    frm_ready = 1'b0;
    for (int f = 0; f < 5; f++) send_frame(1, 2'd0, 8'h00, 8'(8'h30 + f), f < 4);
    idle(3);
    nc++; if (frm_count !== 3'd4) begin nf++; $display("FAIL ffull_count: got %0d, required 4", frm_count); end
    nc++; if (drop_cnt !== 16'd1) begin nf++; $display("FAIL ffull_drop: got %0d, required 1", drop_cnt); end
    frm_ready = 1'b1;
    wait_empty(30, ok);
    idle(2);
    nc++; if (!ok || frm_count !== 3'd0) begin nf++; $display("FAIL ffull_drain: got pending=%0d count=%0d, required 0/0", sb.size(), frm_count); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    frm_ready = 1'b0;
    send_frame(5, 2'd0, 8'h00, 8'h40, 1'b1);
    send_frame(3, 2'd2, 8'h02, 8'h41, 1'b1);
    send_frame(7, 2'd1, 8'h03, 8'h42, 1'b1);
    idle(4);
    frm_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!frm_valid) break;
      n++;
    end
    nc++; if (n !== 15) begin nf++; $display("FAIL b2b_rate: got %0d consecutive words, required 15", n); end
    nc++; if (sb.size() !== 0) begin nf++; $display("FAIL b2b_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    frm_ready = 1'b0;
    send_frame(2, 2'd0, 8'h05, 8'h50, 1'b1);
    for (int i = 0; i < 3; i++) send_word({8'h51, 24'(i)}, i == 0, 1'b0, 2'd0, 8'h00);
    idle(1);
    nc++; if (frm_valid !== 1'b1 || frm_status !== 8'h05) begin nf++; $display("FAIL rmid_pre: got valid=%b st=%h, required 1/05", frm_valid, frm_status); end
    rst_n = 1'b0;
    #2;
    sb.delete();
    nc++; if (frm_valid !== 1'b0 || frm_start !== 1'b0 || frm_data !== 32'd0) begin nf++; $display("FAIL rmid_out: got valid=%b start=%b d=%h, required 0", frm_valid, frm_start, frm_data); end
    nc++; if (frm_status !== 8'd0 || frm_len !== 14'd0 || frm_count !== 3'd0 || drop_cnt !== 16'd0) begin nf++; $display("FAIL rmid_side: got st=%h len=%0d count=%0d drop=%0d, required 0", frm_status, frm_len, frm_count, drop_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    frm_ready = 1'b1;
    idle(6);
    nc++; if (frm_valid !== 1'b0 || frm_count !== 3'd0) begin nf++; $display("FAIL rmid_after: got valid=%b count=%0d, required 0/0", frm_valid, frm_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bytesel();
    test_err();
    test_overflow();
    test_abort();
    test_frames_full();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, required finish before 100000 ns");
    $fatal(1, "timeout");
  end
endmodule
